// File: rtl/reram_pkg.sv
// Shared constants and types for the ReRAM Wishbone arbiter slice.
package reram_pkg;

  localparam int unsigned WB_ADR_W = 32;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_SEL_W = 4;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1,
    StAbort
  } arb_state_e;

endpackage

// File: rtl/reram_wb_arbiter_if.sv
// Classic Wishbone bus bundle; the master modport drives requests, the slave modport answers.
interface reram_wb_arbiter_if;
  import reram_pkg::*;

  logic                cyc;
  logic                stb;
  logic                we;
  logic [WB_SEL_W-1:0] sel;
  logic [WB_ADR_W-1:0] adr;
  logic [WB_DAT_W-1:0] dat_w;  // master to slave
  logic [WB_DAT_W-1:0] dat_r;  // slave to master
  logic                ack;
  logic                err;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack, err
  );

endinterface

// File: rtl/reram_wb_watchdog.sv
// Per-strobe watchdog: counts unacknowledged strobe cycles and flags an abort at the threshold.
module reram_wb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic stb_i,
  input  logic ack_i,
  input  logic irq_clr_i,
  output logic timeout_pulse_o,
  output logic irq_o
);

  logic [15:0] cnt_q, cnt_d;
  logic        irq_q, irq_d;

  // Threshold compare; an ack in the same cycle always wins over the timeout.
  always_comb begin
    timeout_pulse_o = stb_i && !ack_i && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
    cnt_d           = cnt_q + 16'd1;
    if (!stb_i || ack_i || timeout_pulse_o) begin
      cnt_d = '0;
    end
    irq_d = irq_q;
    if (timeout_pulse_o) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
  end

  // Counter and sticky irq state, synchronous reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      irq_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/reram_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the single ReRAM slave port.
module reram_wb_arbiter
  import reram_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  reram_wb_arbiter_if.slave   m0,
  reram_wb_arbiter_if.slave   m1,
  reram_wb_arbiter_if.master  s,
  output logic [1:0]          grant_o,
  output logic                timeout_irq_o,
  input  logic                irq_clr_i
);

  arb_state_e  state_q;
  logic [1:0]  grant_q;
  logic        last_q;
  logic        timeout_pulse;

  reram_wb_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i           (wb_clk_i),
    .rst_ni          (wb_rst_ni),
    .stb_i           (s.stb),
    .ack_i           (s.ack),
    .irq_clr_i       (irq_clr_i),
    .timeout_pulse_o (timeout_pulse),
    .irq_o           (timeout_irq_o)
  );

  // Bus muxes gated by the registered grant; grant is zero in idle and abort so the slave sees
  // nothing and stray acks are dropped. Returns are also masked while reset is asserted.
  always_comb begin
    s.cyc   = (grant_q[0] & m0.cyc) | (grant_q[1] & m1.cyc);
    s.stb   = (grant_q[0] & m0.stb) | (grant_q[1] & m1.stb);
    s.we    = (grant_q[0] & m0.we)  | (grant_q[1] & m1.we);
    s.sel   = ({WB_SEL_W{grant_q[0]}} & m0.sel) | ({WB_SEL_W{grant_q[1]}} & m1.sel);
    s.adr   = ({WB_ADR_W{grant_q[0]}} & m0.adr) | ({WB_ADR_W{grant_q[1]}} & m1.adr);
    s.dat_w = ({WB_DAT_W{grant_q[0]}} & m0.dat_w) | ({WB_DAT_W{grant_q[1]}} & m1.dat_w);

    m0.ack   = grant_q[0] & s.ack & wb_rst_ni;
    m1.ack   = grant_q[1] & s.ack & wb_rst_ni;
    m0.err   = grant_q[0] & timeout_pulse & wb_rst_ni;
    m1.err   = grant_q[1] & timeout_pulse & wb_rst_ni;
    m0.dat_r = (grant_q != 2'b00) ? s.dat_r : '0;
    m1.dat_r = (grant_q != 2'b00) ? s.dat_r : '0;
  end

  // Arbitration FSM; grant is held for the whole bus cycle and the loser of the last
  // ownership wins the next tie.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q <= StIdle;
      grant_q <= 2'b00;
      last_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (m0.cyc && (!m1.cyc || last_q)) begin
            state_q <= StOwn0;
            grant_q <= 2'b01;
          end else if (m1.cyc) begin
            state_q <= StOwn1;
            grant_q <= 2'b10;
          end
        end
        StOwn0: begin
          if (timeout_pulse) begin
            state_q <= StAbort;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end else if (!m0.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b0;
          end
        end
        StOwn1: begin
          if (timeout_pulse) begin
            state_q <= StAbort;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end else if (!m1.cyc) begin
            state_q <= StIdle;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
          end
        end
        StAbort: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
        default: begin
          state_q <= StIdle;
          grant_q <= 2'b00;
        end
      endcase
    end
  end

  assign grant_o = grant_q;

endmodule

// File: tb/tb_reram_wb_arbiter.sv
// Directed bench for reram_wb_arbiter with a read-data scoreboard.
module tb_reram_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  grant;
  logic        irq;
  logic        irq_clr;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [31:0] exp_q[$];

  reram_wb_arbiter_if m0_if ();
  reram_wb_arbiter_if m1_if ();
  reram_wb_arbiter_if s_if ();

  reram_wb_arbiter #(
    .TIMEOUT_CYCLES (8)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_ni     (rst_n),
    .m0            (m0_if),
    .m1            (m1_if),
    .s             (s_if),
    .grant_o       (grant),
    .timeout_irq_o (irq),
    .irq_clr_i     (irq_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pop the next expected read word and compare against what master X sees.
  task automatic sb_pop(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      chk(tag, obs, e);
    end
  endtask

  task automatic idle_masters();
    m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.sel = '0; m0_if.adr = '0; m0_if.dat_w = '0;
    m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.sel = '0; m1_if.adr = '0; m1_if.dat_w = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    irq_clr = 1'b0;
    idle_masters();
    s_if.ack   = 1'b0;
    s_if.err   = 1'b0;
    s_if.dat_r = 32'h0000_1234;  // nonzero to prove read data is gated while idle

    // Reset values
    tick(); tick(); #1;
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("rst_s_stb", 32'(s_if.stb), 32'h0);
    chk("rst_m0_ack", 32'(m0_if.ack), 32'h0);
    chk("rst_m0_err", 32'(m0_if.err), 32'h0);
    chk("rst_m0_dat", m0_if.dat_r, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single read by master 0, slave acks on the third strobe cycle
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.sel = 4'hF; m0_if.adr = 32'h3000_0004;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    chk("rd_arb_latency_stb", 32'(s_if.stb), 32'h0);
    tick(); #1;
    chk("rd_grant", 32'(grant), 32'h1);
    chk("rd_s_stb", 32'(s_if.stb), 32'h1);
    chk("rd_s_adr", s_if.adr, 32'h3000_0004);
    chk("rd_no_early_ack", 32'(m0_if.ack), 32'h0);
    tick(); tick();
    s_if.ack = 1; s_if.dat_r = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_ack", 32'(m0_if.ack), 32'h1);
    sb_pop("rd_m0_dat", m0_if.dat_r);
    chk("rd_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("rd_m1_err", 32'(m1_if.err), 32'h0);
    tick();
    s_if.ack = 0; idle_masters();
    #1;
    chk("rd_ack_one_cycle", 32'(m0_if.ack), 32'h0);
    tick(); #1;
    chk("rd_back_idle", 32'(grant), 32'h0);

    // Tie out of reset: master 0 first, one idle cycle, then master 1
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    m0_if.cyc = 1; m0_if.stb = 1; m1_if.cyc = 1; m1_if.stb = 1;
    tick(); #1;
    chk("tie_first_grant", 32'(grant), 32'h1);
    chk("tie_m1_stalled", 32'(m1_if.ack), 32'h0);
    m0_if.cyc = 0; m0_if.stb = 0;
    tick(); #1;
    chk("tie_idle_gap", 32'(grant), 32'h0);
    tick(); #1;
    chk("tie_second_grant", 32'(grant), 32'h2);
    m1_if.stb = 0;

    // Round-robin: both keep requesting; the owner drops cyc for one cycle between bus cycles
    m0_if.cyc = 1;
    m1_if.cyc = 0;
    tick();              // master 1 releases, IDLE with last = 1
    m1_if.cyc = 1;       // both request in IDLE
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk($sformatf("rr_grant_%0d", i), 32'(grant), (i % 2 == 0) ? 32'h1 : 32'h2);
      if (i % 2 == 0) m0_if.cyc = 0; else m1_if.cyc = 0;
      tick(); #1;
      chk($sformatf("rr_gap_%0d", i), 32'(grant), 32'h0);
      if (i % 2 == 0) m0_if.cyc = 1; else m1_if.cyc = 1;
    end
    idle_masters();
    tick(); #1;
    chk("rr_end_idle", 32'(grant), 32'h0);

    // Timeout: slave never acks; err on the 8th strobe cycle, one abort cycle, sticky irq
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h3000_0010;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("to_err_cycle_%0d", k), 32'(m0_if.err), (k == 8) ? 32'h1 : 32'h0);
      if (k < 8) tick();
    end
    chk("to_irq_not_yet", 32'(irq), 32'h0);
    chk("to_m1_err", 32'(m1_if.err), 32'h0);
    tick(); #1;
    chk("to_abort_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("to_abort_s_stb", 32'(s_if.stb), 32'h0);
    chk("to_abort_err_pulse", 32'(m0_if.err), 32'h0);
    chk("to_irq_set", 32'(irq), 32'h1);
    idle_masters();
    tick(); #1;
    chk("to_irq_sticky", 32'(irq), 32'h1);
    chk("to_idle_grant", 32'(grant), 32'h0);
    irq_clr = 1;
    tick(); #1;
    irq_clr = 0;
    chk("to_irq_cleared", 32'(irq), 32'h0);

    // Ack exactly at the threshold cycle: ack wins, no err, no irq
    m0_if.cyc = 1; m0_if.stb = 1; m0_if.adr = 32'h3000_0020;
    exp_q.push_back(32'hBEEF_0008);
    tick();
    for (int k = 1; k < 8; k++) tick();
    s_if.ack = 1; s_if.dat_r = 32'hBEEF_0008;
    #1;
    chk("thr_ack", 32'(m0_if.ack), 32'h1);
    chk("thr_no_err", 32'(m0_if.err), 32'h0);
    sb_pop("thr_dat", m0_if.dat_r);
    tick();
    s_if.ack = 0; idle_masters();
    #1;
    chk("thr_irq_clear", 32'(irq), 32'h0);
    tick();

    // Reset for one cycle in the middle of a master 1 write
    m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 1; m1_if.sel = 4'h3;
    m1_if.adr = 32'h3000_0040; m1_if.dat_w = 32'hCAFE_F00D;
    tick(); #1;
    chk("wr_grant", 32'(grant), 32'h2);
    chk("wr_s_we", 32'(s_if.we), 32'h1);
    chk("wr_s_dat", s_if.dat_w, 32'hCAFE_F00D);
    tick();
    rst_n = 1'b0;
    #1;
    chk("wr_rst_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("wr_rst_m1_err", 32'(m1_if.err), 32'h0);
    tick(); #1;
    chk("wr_post_rst_grant", 32'(grant), 32'h0);
    chk("wr_post_rst_s_cyc", 32'(s_if.cyc), 32'h0);
    chk("wr_post_rst_s_we", 32'(s_if.we), 32'h0);
    chk("wr_post_rst_s_adr", s_if.adr, 32'h0);
    chk("wr_post_rst_s_dat", s_if.dat_w, 32'h0);
    chk("wr_post_rst_m1_ack", 32'(m1_if.ack), 32'h0);
    chk("wr_post_rst_m1_err", 32'(m1_if.err), 32'h0);
    chk("wr_post_rst_irq", 32'(irq), 32'h0);
    rst_n = 1'b1;
    idle_masters();
    tick();

    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reram_wb_arbiter.md
# reram_wb_arbiter

Two-master Wishbone arbiter that shares the single ReRAM Wishbone slave port (`ReRAM_Wishbone_Interface`) between the Caravel management Wishbone bus (master 0) and an on-chip requester such as an inference sequencer (master 1). It sits in `user_project_wrapper` between the bus sources and the ReRAM slave. It grants the slave to one master per bus cycle with round-robin fairness. A per-transfer watchdog aborts any access the slave fails to acknowledge.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles with `stb` asserted and no `ack` before abort; legal range 2..65535.
- `wb_clk_i`  in  1  single clock; all logic on its rising edge.
- `wb_rst_ni`  in  1  reset; synchronous and active-low.
- `m0_cyc_i`, `m0_stb_i`, `m0_we_i`  in  1 each  master 0 (Caravel) cycle, strobe and write enable.
- `m0_sel_i`  in  4  master 0 byte selects.
- `m0_adr_i`, `m0_dat_i`  in  32 each  master 0 address and write data.
- `m0_dat_o`  out  32  master 0 read data.
- `m0_ack_o`, `m0_err_o`  out  1 each  master 0 acknowledge and error.
- `m1_*`  same set and widths  master 1 (on-chip requester).
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  to ReRAM slave.
- `s_sel_o`  out  4  to ReRAM slave.
- `s_adr_o`, `s_dat_o`  out  32 each  to ReRAM slave.
- `s_dat_i`, `s_ack_i`  in  32, 1  from ReRAM slave.
- `grant_o`  out  2  one-hot current owner; `00` when idle.
- `timeout_irq_o`  out  1  sticky flag, set on any abort.
- `irq_clr_i`  in  1  clears `timeout_irq_o`.

## Operation
- FSM states: IDLE, OWN0, OWN1, ABORT.
- IDLE: if only one `mX_cyc_i` is high, go to OWNX. If both are high, go to the master that was not granted last. The `last` register resets to 1, so master 0 wins the first tie.
- OWNX: the slave `cyc/stb/we/sel/adr/dat` are muxed combinationally from master X, gated by the registered grant. `s_ack_i` routes to `mX_ack_o` only. `s_dat_i` drives both `mX_dat_o`; data is valid only with ack.
- The grant is held for the whole Wishbone cycle, including multiple strobes, until `mX_cyc_i` falls. Then the FSM returns to IDLE and sets `last = X`.
- The non-granted master sees `ack = 0` and `err = 0` and stalls.
- Watchdog: a 16-bit counter clears on every `s_ack_i` and whenever `stb` is low. It increments while the granted `stb` is high without ack.
- When the count reaches `TIMEOUT_CYCLES-1` with no ack that cycle: pulse `mX_err_o` for one cycle, set `timeout_irq_o`, and enter ABORT.
- ABORT: hold all `s_*` outputs low for exactly one cycle, then go to IDLE with `last = X`.
- `s_ack_i` in the same cycle as the timeout threshold: the ack wins. No err is raised and the counter clears.
- `s_ack_i` while in IDLE or ABORT is ignored and not forwarded.
- `irq_clr_i` and a new timeout in the same cycle: set wins.
- Reset mid-transfer: the FSM goes to IDLE; the in-flight transfer is dropped and no ack or err is issued.

## Timing
- Reset values: all `s_*` outputs 0, `grant_o = 00`, `mX_ack_o = 0`, `mX_err_o = 0`, `mX_dat_o = 0`, `timeout_irq_o = 0`, counter 0, `last = 1`.
- Arbitration latency: `cyc` rises in cycle N, the grant registers at edge N+1, and the slave sees `stb` in cycle N+1.
- Ack path: `s_ack_i` to `mX_ack_o` is combinational, with zero added latency. Total added latency is 1 cycle per bus cycle, not per strobe.
- Back-to-back cycles: one IDLE cycle is required between owners. Master 1 can therefore be granted at the earliest 2 cycles after master 0 drops `cyc`.
- Err: a single-cycle pulse in the cycle the counter hits the threshold. ABORT follows for 1 cycle, then IDLE.

## Structure
- Shared package `reram_pkg`:
  - FSM state encoding enum.
  - Wishbone width constants (`WB_ADR_W = 32`, `WB_DAT_W = 32`, `WB_SEL_W = 4`).
  - Default `TIMEOUT_CYCLES`.
- One sub-module `reram_wb_watchdog`: counter, threshold compare and sticky irq; outputs a `timeout_pulse`.
- The arbiter FSM and the muxes live in the top module.

## Test plan
- Single read: master 0 reads address `0x3000_0004` and the slave acks after 3 cycles with `0xDEAD_BEEF`. Required: `m0_ack_o` for 1 cycle with `m0_dat_o = 0xDEAD_BEEF`, `grant_o = 01`, master 1 untouched.
- Tie out of reset: both masters raise `cyc` in the same cycle. Required: master 0 is granted first. After master 0 drops `cyc`, one IDLE cycle follows, then `grant_o = 10`.
- Round-robin: master 0 re-requests continuously while master 1 also requests. Required: grants alternate 0, 1, 0, 1 over 4 cycles and neither master is granted twice in a row.
- Timeout: with `TIMEOUT_CYCLES = 8`, the slave never acks. Required: `m0_err_o` pulses at the 8th `stb` cycle, `s_cyc_o` is low for 1 cycle, `timeout_irq_o = 1` until `irq_clr_i`.
- Ack at threshold: the slave acks exactly at the 8th cycle. Required: `m0_ack_o = 1`, `m0_err_o = 0`, `timeout_irq_o` stays 0.
- Reset mid-write: `wb_rst_ni` is low for 1 cycle during an OWN1 write. Required: next cycle all outputs are at reset values and no ack or err reaches master 1.
